// File: rtl/mdl_pgctrl_if.sv
// mdl_pgctrl_if: handshake/bus bundle for the page-transfer sequencer
//   slave  : sequencer side (takes request, clock enable, abort, shift flag; drives ring, strobes, status)
//   master : requester / page-register side
interface mdl_pgctrl_if #(
    parameter int PG_W    = 12,
    parameter int ROT_LEN = 20,
    parameter int BURST_W = 4
);
    logic               i_CLK2M_PCEN_n;
    logic               i_REQ;
    logic [PG_W-1:0]    i_PAGE;
    logic [BURST_W-1:0] i_BURST;
    logic               i_ABORT;
    logic               i_PGREG_SR_SHIFT;
    logic               o_ACK;
    logic               o_BUSY;
    logic               o_DONE;
    logic               o_ERR;
    logic [ROT_LEN-1:0] o_ROT20_n;
    logic               o_PGREG_LD;
    logic [15:0]        o_PGREG_DIN;
    logic               o_PGREG_SR_LD_EN;
    logic [PG_W-1:0]    o_CUR_PAGE;
    logic               o_PAGE_STRB;
    modport slave (
        input  i_CLK2M_PCEN_n, i_REQ, i_PAGE, i_BURST, i_ABORT, i_PGREG_SR_SHIFT,
        output o_ACK, o_BUSY, o_DONE, o_ERR, o_ROT20_n, o_PGREG_LD, o_PGREG_DIN,
               o_PGREG_SR_LD_EN, o_CUR_PAGE, o_PAGE_STRB
    );
    modport master (
        output i_CLK2M_PCEN_n, i_REQ, i_PAGE, i_BURST, i_ABORT, i_PGREG_SR_SHIFT,
        input  o_ACK, o_BUSY, o_DONE, o_ERR, o_ROT20_n, o_PGREG_LD, o_PGREG_DIN,
               o_PGREG_SR_LD_EN, o_CUR_PAGE, o_PAGE_STRB
    );
endinterface

// File: rtl/mdl_pgctrl.sv
// mdl_pgctrl: page-burst sequencer driving the page register / page shift register pair
//   i_MCLK      : master clock
//   i_SYS_RST_n : synchronous active-low reset
//   bus         : mdl_pgctrl_if.slave (request/ack, burst setup, abort, clock enable,
//                 rotation ring, page-register strobes, status)
module mdl_pgctrl #(
    parameter int PG_W    = 12,
    parameter int ROT_LEN = 20,
    parameter int BURST_W = 4,
    parameter int CHK_POS = 16
) (
    input logic         i_MCLK,
    input logic         i_SYS_RST_n,
    mdl_pgctrl_if.slave bus
);
    localparam int REM_W = BURST_W + 1;
    typedef enum logic [2:0] {IDLE, LATCH, ARM, SHIFT, NEXT, DONE} state_t;
    state_t             state_q, state_d;
    logic [ROT_LEN-1:0] rot_q, rot_d;
    logic [PG_W-1:0]    cur_q, cur_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [15:0]        din_q, din_d;
    logic               err_q, err_d;
    logic               first_q, first_d;
    logic               tick, tick_last, tick_chk;
    assign tick      = !bus.i_CLK2M_PCEN_n;
    assign tick_last = tick && !rot_q[ROT_LEN-1];
    assign tick_chk  = tick && !rot_q[CHK_POS];
    always_comb begin
        rot_d   = tick ? {rot_q[ROT_LEN-2:0], rot_q[ROT_LEN-1]} : rot_q;
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        err_d   = err_q;
        first_d = first_q;
        case (state_q)
            IDLE: if (bus.i_REQ) begin
                cur_d   = bus.i_PAGE;
                rem_d   = REM_W'(bus.i_BURST) + REM_W'(1);
                err_d   = 1'b0;
                first_d = 1'b1;
                state_d = LATCH;
            end
            LATCH: begin
                first_d = 1'b0;
                state_d = ARM;
            end
            ARM: state_d = tick_last ? SHIFT : ARM;
            SHIFT: begin
                err_d   = err_q | (tick_chk & !bus.i_PGREG_SR_SHIFT);
                state_d = tick_last ? NEXT : SHIFT;
            end
            NEXT: if (rem_q == REM_W'(1)) begin
                state_d = DONE;
            end else begin
                cur_d   = cur_q + PG_W'(1);
                rem_d   = rem_q - REM_W'(1);
                state_d = LATCH;
            end
            default: state_d = IDLE;
        endcase
        // abort discards whatever this cycle would have done, keeping page and error intact
        if (state_q != IDLE && bus.i_ABORT) begin
            state_d = IDLE;
            cur_d   = cur_q;
            err_d   = err_q;
        end
        // page data is latched on entry to LATCH so it is valid during the LD strobe
        din_d = state_d == LATCH ? 16'(cur_d) : din_q;
    end
    always_ff @(posedge i_MCLK) begin
        if (!i_SYS_RST_n) begin
            state_q <= IDLE;
            rot_q   <= ~ROT_LEN'(1);
            cur_q   <= '0;
            rem_q   <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            din_q   <= din_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end
    assign bus.o_ACK            = state_q == LATCH && first_q;
    assign bus.o_BUSY           = state_q != IDLE;
    assign bus.o_DONE           = state_q == DONE;
    assign bus.o_ERR            = err_q;
    assign bus.o_ROT20_n        = rot_q;
    assign bus.o_PGREG_LD       = state_q == LATCH;
    assign bus.o_PGREG_DIN      = din_q;
    assign bus.o_PGREG_SR_LD_EN = state_q == ARM;
    assign bus.o_CUR_PAGE       = cur_q;
    assign bus.o_PAGE_STRB      = state_q == NEXT;
endmodule

// File: tb/tb_mdl_pgctrl.sv
// tb_mdl_pgctrl: randomized + directed bench for mdl_pgctrl against a tick-counting reference model
module tb_mdl_pgctrl;
    localparam int PG_W    = 12;
    localparam int ROT_LEN = 20;
    localparam int BURST_W = 4;
    localparam int CHK_POS = 16;
    localparam int S_IDLE = 0, S_LATCH = 1, S_ARM = 2, S_SHIFT = 3, S_NEXT = 4, S_DONE = 5;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    mdl_pgctrl_if #(.PG_W(PG_W), .ROT_LEN(ROT_LEN), .BURST_W(BURST_W)) bus ();
    mdl_pgctrl #(.PG_W(PG_W), .ROT_LEN(ROT_LEN), .BURST_W(BURST_W), .CHK_POS(CHK_POS)) dut (
        .i_MCLK(clk),
        .i_SYS_RST_n(rst_n),
        .bus(bus)
    );
    int n_tests = 0;
    int n_fail  = 0;
    // reference model: ring position, burst phase, pages left, ticks since shift-register load
    int m_pos, m_ph, m_cur, m_rem, m_din, m_ticks;
    bit m_err, m_first;
    int n_ack, n_done, n_strb;
    int ld_pages[$];
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_rot();
        logic [ROT_LEN-1:0] r = '1;
        r[m_pos] = 1'b0;
        return 32'(r);
    endfunction
    task automatic model_step();
        bit tk = !bus.i_CLK2M_PCEN_n;
        if (!rst_n) begin
            m_pos = 0; m_ph = S_IDLE; m_cur = 0; m_rem = 0; m_din = 0; m_ticks = 0;
            m_err = 0; m_first = 0;
            return;
        end
        if (m_ph != S_IDLE && bus.i_ABORT) m_ph = S_IDLE;
        else case (m_ph)
            S_IDLE: if (bus.i_REQ) begin
                m_cur = int'(bus.i_PAGE); m_rem = int'(bus.i_BURST) + 1;
                m_err = 0; m_first = 1; m_din = m_cur; m_ph = S_LATCH;
            end
            S_LATCH: begin m_first = 0; m_ph = S_ARM; end
            S_ARM: if (tk && m_pos == ROT_LEN - 1) begin m_ph = S_SHIFT; m_ticks = 0; end
            S_SHIFT: if (tk) begin
                m_ticks++;
                if (m_ticks == CHK_POS + 1 && !bus.i_PGREG_SR_SHIFT) m_err = 1;
                if (m_ticks == ROT_LEN) m_ph = S_NEXT;
            end
            S_NEXT: if (m_rem == 1) m_ph = S_DONE;
                else begin
                    m_cur = (m_cur + 1) % (1 << PG_W); m_rem--; m_din = m_cur; m_ph = S_LATCH;
                end
            default: m_ph = S_IDLE;
        endcase
        if (tk) m_pos = (m_pos + 1) % ROT_LEN;
    endtask
    task automatic cyc();
        model_step();
        @(negedge clk);
        check("rot", 32'(bus.o_ROT20_n), exp_rot());
        check("ack_busy_done_err_ld_srld_strb",
              32'({bus.o_ACK, bus.o_BUSY, bus.o_DONE, bus.o_ERR, bus.o_PGREG_LD, bus.o_PGREG_SR_LD_EN, bus.o_PAGE_STRB}),
              32'({m_ph == S_LATCH && m_first, m_ph != S_IDLE, m_ph == S_DONE, m_err,
                   m_ph == S_LATCH, m_ph == S_ARM, m_ph == S_NEXT}));
        check("din", 32'(bus.o_PGREG_DIN), 32'(m_din));
        check("cur_page", 32'(bus.o_CUR_PAGE), 32'(m_cur));
        n_ack  += int'(bus.o_ACK);
        n_done += int'(bus.o_DONE);
        n_strb += int'(bus.o_PAGE_STRB);
        if (bus.o_PGREG_LD) ld_pages.push_back(int'(bus.o_PGREG_DIN));
    endtask
    task automatic clr_counts();
        n_ack = 0; n_done = 0; n_strb = 0;
        ld_pages.delete();
    endtask
    task automatic start(int page, int burst);
        clr_counts();
        bus.i_REQ = 1'b1; bus.i_PAGE = PG_W'(page); bus.i_BURST = BURST_W'(burst);
        cyc();
        bus.i_REQ = 1'b0;
    endtask
    task automatic wait_done(string tag, int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            cyc();
            seen = bus.o_DONE;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
    endtask
    initial begin
        int exp_pg[3] = '{32'h0FFE, 32'h0FFF, 32'h0000};
        rst_n = 1'b0;
        bus.i_REQ = 1'b0; bus.i_PAGE = '0; bus.i_BURST = '0; bus.i_ABORT = 1'b0;
        bus.i_PGREG_SR_SHIFT = 1'b1; bus.i_CLK2M_PCEN_n = 1'b0;
        repeat (3) cyc();
        check("rst_rot", 32'(bus.o_ROT20_n), 32'h000FFFFE);
        check("rst_ctrl", 32'({bus.o_ACK, bus.o_BUSY, bus.o_DONE, bus.o_ERR, bus.o_PGREG_LD,
                                bus.o_PGREG_SR_LD_EN, bus.o_PAGE_STRB}), 0);
        check("rst_cur_din", 32'({bus.o_CUR_PAGE, bus.o_PGREG_DIN}), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bus.i_CLK2M_PCEN_n = (i % 4) != 0;
            cyc();
        end
        check("t1_ring_wrap", 32'(bus.o_ROT20_n), 32'h000FFFFE);
        bus.i_CLK2M_PCEN_n = 1'b0;
        start(12'h123, 0);
        check("t2_ack", 32'(bus.o_ACK), 1);
        check("t2_din", 32'(bus.o_PGREG_DIN), 32'h0123);
        wait_done("t2", 200);
        check("t2_strb", n_strb, 1);
        cyc();
        check("t2_busy_off", 32'(bus.o_BUSY), 0);
        start(12'hFFE, 2);
        wait_done("t3", 400);
        check("t3_strb", n_strb, 3);
        check("t3_ack", n_ack, 1);
        check("t3_done", n_done, 1);
        check("t3_ld_count", ld_pages.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t3_page%0d", i), i < ld_pages.size() ? ld_pages[i] : 32'hDEAD, exp_pg[i]);
        cyc();
        bus.i_PGREG_SR_SHIFT = 1'b0;
        start(12'h055, 1);
        wait_done("t4", 300);
        check("t4_err_at_done", 32'(bus.o_ERR), 1);
        cyc();
        bus.i_PGREG_SR_SHIFT = 1'b1;
        start(12'h056, 0);
        check("t4_err_clr", 32'(bus.o_ERR), 0);
        wait_done("t4b", 200);
        cyc();
        start(12'h200, 0);
        for (int i = 0; i < 60 && !(m_ph == S_ARM && m_pos == ROT_LEN - 1); i++) cyc();
        check("t5_reach_arm19", 32'(m_ph == S_ARM && m_pos == ROT_LEN - 1), 1);
        bus.i_ABORT = 1'b1;
        cyc();
        bus.i_ABORT = 1'b0;
        check("t5_busy", 32'(bus.o_BUSY), 0);
        check("t5_ring_pos0", 32'(bus.o_ROT20_n), 32'h000FFFFE);
        repeat (30) cyc();
        check("t5_no_strb_done", n_strb + n_done, 0);
        check("t5_cur_kept", 32'(bus.o_CUR_PAGE), 32'h200);
        start(12'h300, 0);
        for (int i = 0; i < 60 && m_ph != S_SHIFT; i++) cyc();
        bus.i_REQ = 1'b1;
        repeat (3) cyc();
        check("t6_req_ignored", n_ack, 1);
        wait_done("t6", 100);
        cyc();
        check("t6_ack_plus1", 32'(bus.o_ACK), 0);
        cyc();
        check("t6_ack_plus2", 32'(bus.o_ACK), 1);
        bus.i_REQ = 1'b0;
        bus.i_ABORT = 1'b1;
        cyc();
        bus.i_ABORT = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            rst_n = $urandom_range(0, 599) != 0;
            bus.i_REQ = ($urandom % 4) == 0;
            bus.i_PAGE = PG_W'($urandom);
            bus.i_BURST = BURST_W'($urandom_range(0, 3));
            bus.i_ABORT = ($urandom % 60) == 0;
            bus.i_PGREG_SR_SHIFT = ($urandom % 8) != 0;
            bus.i_CLK2M_PCEN_n = $urandom % 2;
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mdl_pgctrl.md
Name: mdl_pgctrl

Overview:
Page-transfer sequencer for the bubble controller's page register / page shift register pair. It owns the free-running 20-step active-low rotation ring (ROT20_n) and accepts a page-burst request through a req/ack handshake. For each page it pulses the page-register load, arms the shift-register load at rotation slot 19, then supervises one full rotation of shifting. It then auto-increments the page and repeats for the programmed burst length, reporting completion, abort and timing errors.

Parameters:
PG_W, 12, page number width (page register width)
ROT_LEN, 20, rotation ring length; positions 0..ROT_LEN-1
BURST_W, 4, burst length field width; pages per burst = i_BURST+1
CHK_POS, 16, rotation position at which the shift flag is checked

Ports:
i_MCLK  in  1  master clock
i_SYS_RST_n  in  1  reset, synchronous, active-low
i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active-low; ring and slot logic advance only when 0
i_REQ  in  1  burst request, level; sampled only in IDLE
i_PAGE  in  PG_W  start page
i_BURST  in  BURST_W  burst length minus one
i_ABORT  in  1  abort current burst
i_PGREG_SR_SHIFT  in  1  shift flag returned by the page register block
o_ACK  out  1  one-MCLK pulse: request accepted
o_BUSY  out  1  high in any state other than IDLE
o_DONE  out  1  one-MCLK pulse: burst completed normally
o_ERR  out  1  sticky shift-flag error
o_ROT20_n  out  ROT_LEN  one-hot active-low rotation ring
o_PGREG_LD  out  1  page register latch strobe
o_PGREG_DIN  out  16  data to page register: {zeros, current page}
o_PGREG_SR_LD_EN  out  1  shift-register load enable
o_CUR_PAGE  out  PG_W  page currently in flight
o_PAGE_STRB  out  1  one-MCLK pulse: a page's rotation completed

Behaviour:
- All state is registered on posedge i_MCLK. Reset is synchronous with the highest priority.
- Reset values:
  - o_ROT20_n = all ones except bit0 = 0 (position 0).
  - State = IDLE.
  - o_ACK, o_BUSY, o_DONE, o_ERR, o_PGREG_LD, o_PGREG_SR_LD_EN and o_PAGE_STRB = 0.
  - o_CUR_PAGE = 0; o_PGREG_DIN = 0.
- Rotation ring:
  - Free-running. Advances one position on every MCLK where i_CLK2M_PCEN_n = 0, and wraps 19 -> 0.
  - It never stalls and is unaffected by FSM state or abort.
  - "Tick at position p" means a cycle with CEN active while bit p of o_ROT20_n = 0.
- The FSM has six states: IDLE, LATCH, ARM, SHIFT, NEXT, DONE.
- IDLE:
  - When i_REQ = 1, capture i_PAGE into o_CUR_PAGE and capture remaining = i_BURST+1 (range 1..16).
  - Clear o_ERR, then go to LATCH.
- LATCH (exactly one MCLK):
  - o_PGREG_LD = 1 and o_PGREG_DIN = {4'h0, o_CUR_PAGE}.
  - o_ACK = 1 only on the first LATCH of a burst.
  - o_PGREG_DIN holds its value until the next LATCH.
  - Next state: ARM.
- ARM:
  - o_PGREG_SR_LD_EN = 1.
  - Wait for a tick at position 19, at which the shift register loads; go to SHIFT on that tick.
  - o_PGREG_SR_LD_EN drops the cycle after that tick.
- SHIFT:
  - On a tick at CHK_POS, if i_PGREG_SR_SHIFT = 0 then set o_ERR (sticky). The FSM continues regardless.
  - On the next tick at position 19 (one full rotation after the load), pulse o_PAGE_STRB and go to NEXT.
- NEXT (one MCLK):
  - If remaining = 1, go to DONE.
  - Otherwise: o_CUR_PAGE += 1, modulo 2^PG_W (0xFFF wraps to 0x000); remaining -= 1; go to LATCH.
- DONE (one MCLK): o_DONE = 1, then go to IDLE.
- Handshake and abort:
  - i_REQ outside IDLE is ignored, with no ack and no queueing. A REQ held high through DONE starts a new burst on the following IDLE cycle.
  - i_ABORT = 1 in any non-IDLE state forces IDLE on the next cycle. o_PGREG_LD and o_PGREG_SR_LD_EN are 0 from that cycle, and o_DONE / o_PAGE_STRB are not pulsed.
  - o_CUR_PAGE retains its value after an abort.
  - Priority: reset > abort > normal transitions.
- Latency:
  - REQ sampled at cycle n gives ACK + LD at n+1 and SR_LD_EN from n+2.
  - A page whose ARM misses the current position-19 tick waits for the next one, up to one rotation.
- Simultaneous events:
  - A position-19 tick in ARM together with abort: abort wins, and no transition to SHIFT occurs.
  - After the SHIFT-ending tick at 19, the next page's ARM waits for the following position-19 tick.

Test Plan:
1. Reset -> o_ROT20_n = 20'hFFFFE; with CEN active every 4th MCLK, returns to 20'hFFFFE after 80 MCLK; all control outputs 0.
2. REQ with PAGE = 0x123, BURST = 0 -> ACK + LD one cycle later with o_PGREG_DIN = 16'h0123; SR_LD_EN held until the pos-19 tick; one PAGE_STRB 20 ticks later; DONE; BUSY deasserts.
3. PAGE = 0xFFE, BURST = 2 -> pages 0xFFE, 0xFFF, 0x000 presented on successive LATCHes; three PAGE_STRBs; one ACK; one DONE.
4. Hold i_PGREG_SR_SHIFT = 0 throughout a burst -> o_ERR set at the first pos-16 tick and remains set through DONE; cleared when the next REQ is accepted.
5. Assert i_ABORT during ARM coincident with a pos-19 tick -> IDLE next cycle; no PAGE_STRB, no DONE; ring phase unchanged.
6. Pulse REQ during SHIFT -> ignored (no ACK); a REQ held through DONE -> new ACK exactly 2 MCLK after DONE.
